// File: rtl/operand_queue_pkg.sv
// Shared opcode encoding for the operand queue and its controller.
package operand_queue_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP       = 3'b000,
    OP_PUSH      = 3'b001,
    OP_POP       = 3'b010,
    OP_POP2_PUSH = 3'b011,
    OP_CLEAR     = 3'b100
  } opcode_e;

endpackage

// File: rtl/operand_queue_if.sv
// Controller <-> operand queue bundle: operation request and queue status.
interface operand_queue_if
  import operand_queue_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int AW = $clog2(DEPTH);

  logic                  op_valid;
  logic [OPCODE_W-1:0]   opcode;
  logic [DATA_W-1:0]     din;
  logic                  err_clr;
  logic [2*DATA_W-1:0]   top_conc;
  logic                  pair_valid;
  logic [AW:0]           count;
  logic                  full;
  logic                  empty;
  logic                  op_done;
  logic                  op_ok;
  logic                  err_ovf;
  logic                  err_udf;

  modport master (
    output op_valid, opcode, din, err_clr,
    input  top_conc, pair_valid, count, full, empty, op_done, op_ok, err_ovf, err_udf
  );

  modport slave (
    input  op_valid, opcode, din, err_clr,
    output top_conc, pair_valid, count, full, empty, op_done, op_ok, err_ovf, err_udf
  );
endinterface

// File: rtl/operand_queue_storage.sv
// Unreset entry array: one synchronous write port, two asynchronous read ports.
module queue_storage #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr0,
  input  logic [$clog2(DEPTH)-1:0]   raddr1,
  output logic [DATA_W-1:0]          rdata0,
  output logic [DATA_W-1:0]          rdata1
);
  logic [DATA_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata0 = mem_reg[raddr0];
  assign rdata1 = mem_reg[raddr1];
endmodule

// File: rtl/operand_queue.sv
// Circular operand queue: pointer/count control, legality decode, sticky
// error flags and the op_done/op_ok status pulse.
module operand_queue
  import operand_queue_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic            clk,
  input  logic            rst,
  operand_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     head_reg, head_next;
  logic [AW-1:0]     tail_reg, tail_next;
  logic [AW:0]       count_reg, count_next;
  logic              err_ovf_reg, err_ovf_next;
  logic              err_udf_reg, err_udf_next;
  logic              op_done_reg, op_ok_reg;
  logic              legal, set_ovf, set_udf, do_clear, wr_en;
  logic              full_w, empty_w;
  logic [DATA_W-1:0] front_raw, second_raw;

  assign full_w  = (count_reg == (AW+1)'(DEPTH));
  assign empty_w = (count_reg == '0);

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    legal      = 1'b0;
    set_ovf    = 1'b0;
    set_udf    = 1'b0;
    do_clear   = 1'b0;
    wr_en      = 1'b0;
    if (bus.op_valid) begin
      case (bus.opcode)
        OP_NOP: legal = 1'b1;
        OP_PUSH: begin
          if (full_w) begin
            set_ovf = 1'b1;
          end else begin
            legal      = 1'b1;
            wr_en      = 1'b1;
            tail_next  = tail_reg + AW'(1);
            count_next = count_reg + (AW+1)'(1);
          end
        end
        OP_POP: begin
          if (empty_w) begin
            set_udf = 1'b1;
          end else begin
            legal      = 1'b1;
            head_next  = head_reg + AW'(1);
            count_next = count_reg - (AW+1)'(1);
          end
        end
        OP_POP2_PUSH: begin
          // When full, tail equals head: the write lands in the slot being vacated.
          if (count_reg < (AW+1)'(2)) begin
            set_udf = 1'b1;
          end else begin
            legal      = 1'b1;
            wr_en      = 1'b1;
            head_next  = head_reg + AW'(2);
            tail_next  = tail_reg + AW'(1);
            count_next = count_reg - (AW+1)'(1);
          end
        end
        OP_CLEAR: begin
          legal      = 1'b1;
          do_clear   = 1'b1;
          head_next  = '0;
          tail_next  = '0;
          count_next = '0;
        end
        default: set_udf = 1'b1;
      endcase
    end
    // A new error in the same cycle as err_clr keeps the flag set.
    err_ovf_next = (err_ovf_reg & ~bus.err_clr & ~do_clear) | set_ovf;
    err_udf_next = (err_udf_reg & ~bus.err_clr & ~do_clear) | set_udf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      err_ovf_reg <= 1'b0;
      err_udf_reg <= 1'b0;
      op_done_reg <= 1'b0;
      op_ok_reg   <= 1'b0;
    end else begin
      head_reg    <= head_next;
      tail_reg    <= tail_next;
      count_reg   <= count_next;
      err_ovf_reg <= err_ovf_next;
      err_udf_reg <= err_udf_next;
      op_done_reg <= bus.op_valid;
      op_ok_reg   <= legal;
    end
  end

  queue_storage #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_storage (
    .clk    (clk),
    .we     (wr_en),
    .waddr  (tail_reg),
    .wdata  (bus.din),
    .raddr0 (head_reg),
    .raddr1 (head_reg + AW'(1)),
    .rdata0 (front_raw),
    .rdata1 (second_raw)
  );

  assign bus.top_conc   = {(empty_w ? '0 : front_raw),
                           ((count_reg >= (AW+1)'(2)) ? second_raw : '0)};
  assign bus.pair_valid = (count_reg >= (AW+1)'(2));
  assign bus.count      = count_reg;
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;
  assign bus.op_done    = op_done_reg;
  assign bus.op_ok      = op_ok_reg;
  assign bus.err_ovf    = err_ovf_reg;
  assign bus.err_udf    = err_udf_reg;
endmodule
